// File: rtl/pulse_period_meter_pkg.sv
// Shared types for the pulse period meter: measurement state encoding.
package pulse_period_meter_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_e;

endpackage

// File: rtl/pulse_period_meter_if.sv
// Control, pulse input, result handshake and flag signals of the period meter.
interface pulse_period_meter_if #(parameter int WIDTH = 32);

  logic             enable;
  logic             in_pulse;
  logic             clear_flags;
  logic             period_ready;
  logic [WIDTH-1:0] period_out;
  logic             period_valid;
  logic             timeout;
  logic             overrun;

  modport master (
    output enable, in_pulse, clear_flags, period_ready,
    input  period_out, period_valid, timeout, overrun
  );

  modport slave (
    input  enable, in_pulse, clear_flags, period_ready,
    output period_out, period_valid, timeout, overrun
  );

endinterface

// File: rtl/pulse_period_meter_rising_edge_detect.sv
// One-flop rising edge detector; the flop resets low so a high input right after reset is an edge.
module rising_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic in_i,
  output logic pulse_o
);

  logic in_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in_i;
    end
  end

  assign pulse_o = in_i & ~in_q;

endmodule

// File: rtl/pulse_period_meter.sv
// Counts clock cycles between rising edges of in_pulse and presents each interval on a
// valid/ready output, with a one-cycle timeout pulse and a sticky overrun flag.
module pulse_period_meter
  import pulse_period_meter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  pulse_period_meter_if.slave  bus
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             overrun_q, overrun_d;
  logic             pulse_edge;
  logic             result_vld;

  rising_edge_detect u_edge (
    .clock   (clock),
    .reset   (reset),
    .in_i    (bus.in_pulse),
    .pulse_o (pulse_edge)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    result_vld = 1'b0;
    timeout_d  = 1'b0;
    if (!bus.enable) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pulse_edge) begin
            count_d = CNT_ONE;
            state_d = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (pulse_edge) begin
            result_vld = 1'b1;
            count_d    = CNT_ONE;
          end else if (count_q == CNT_MAX) begin
            // Saturated with no edge: abandon the interval rather than report a wrapped value.
            timeout_d = 1'b1;
            count_d   = '0;
            state_d   = ST_IDLE;
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    period_d  = period_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (bus.clear_flags) begin
      overrun_d = 1'b0;
    end
    // A drop in the same cycle as clear_flags leaves overrun set.
    if (result_vld) begin
      if (!valid_q || bus.period_ready) begin
        period_d = count_q;
        valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && bus.period_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.period_out   = period_q;
  assign bus.period_valid = valid_q;
  assign bus.timeout      = timeout_q;
  assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter (WIDTH=4): periods, backpressure, timeout, level, reset, enable.
module tb_pulse_period_meter;

  logic clock = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  pulse_period_meter_if #(.WIDTH(4)) bus ();

  pulse_period_meter #(.WIDTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Drive a one-cycle pulse; returns just after the posedge that sampled it.
  task automatic pulse1();
    bus.in_pulse = 1'b1;
    tick(1);
    bus.in_pulse = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-16s observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    reset            = 1'b1;
    bus.enable       = 1'b0;
    bus.in_pulse     = 1'b0;
    bus.clear_flags  = 1'b0;
    bus.period_ready = 1'b0;
    tick(2);
    chk("rst_period", 32'(bus.period_out), 0);
    chk("rst_valid", 32'(bus.period_valid), 0);
    chk("rst_timeout", 32'(bus.timeout), 0);
    chk("rst_overrun", 32'(bus.overrun), 0);
    reset = 1'b0;

    // Period 5 with consumer always ready
    bus.enable = 1'b1;
    bus.period_ready = 1'b1;
    pulse1();
    chk("p5_arm_valid", 32'(bus.period_valid), 0);
    tick(4);
    pulse1();
    chk("p5_period_a", 32'(bus.period_out), 5);
    chk("p5_valid_a", 32'(bus.period_valid), 1);
    tick(1);
    chk("p5_consumed", 32'(bus.period_valid), 0);
    tick(3);
    pulse1();
    chk("p5_period_b", 32'(bus.period_out), 5);
    chk("p5_valid_b", 32'(bus.period_valid), 1);

    // Period 7 with backpressure: second result dropped
    tick(1);
    bus.period_ready = 1'b0;
    tick(5);
    pulse1();
    chk("p7_period", 32'(bus.period_out), 7);
    chk("p7_valid", 32'(bus.period_valid), 1);
    chk("p7_no_overrun", 32'(bus.overrun), 0);
    tick(6);
    pulse1();
    chk("p7_drop_period", 32'(bus.period_out), 7);
    chk("p7_overrun", 32'(bus.overrun), 1);
    bus.period_ready = 1'b1;
    tick(1);
    chk("p7_accept_valid", 32'(bus.period_valid), 0);
    chk("p7_held_overrun", 32'(bus.overrun), 1);
    bus.clear_flags = 1'b1;
    tick(1);
    bus.clear_flags = 1'b0;
    chk("p7_cleared", 32'(bus.overrun), 0);

    // Level held 10 high, 3 low, then high: one period of 13
    bus.enable = 1'b0;
    tick(1);
    bus.enable = 1'b1;
    bus.in_pulse = 1'b1;
    tick(1);
    chk("lvl_arm_valid", 32'(bus.period_valid), 0);
    tick(9);
    chk("lvl_hold_valid", 32'(bus.period_valid), 0);
    bus.in_pulse = 1'b0;
    tick(3);
    bus.in_pulse = 1'b1;
    tick(1);
    bus.in_pulse = 1'b0;
    chk("lvl_period", 32'(bus.period_out), 13);
    chk("lvl_valid", 32'(bus.period_valid), 1);

    // Timeout 15 cycles after a lone edge, then re-arm and measure 6
    bus.enable = 1'b0;
    tick(1);
    bus.enable = 1'b1;
    pulse1();
    tick(14);
    chk("to_before", 32'(bus.timeout), 0);
    tick(1);
    chk("to_pulse", 32'(bus.timeout), 1);
    chk("to_no_result", 32'(bus.period_valid), 0);
    tick(1);
    chk("to_after", 32'(bus.timeout), 0);
    pulse1();
    chk("to_rearm_valid", 32'(bus.period_valid), 0);
    tick(5);
    pulse1();
    chk("to_p6_period", 32'(bus.period_out), 6);
    chk("to_p6_valid", 32'(bus.period_valid), 1);

    // Reset with the counter at 3, then period 4
    tick(2);
    reset = 1'b1;
    #1;
    chk("mid_rst_period", 32'(bus.period_out), 0);
    chk("mid_rst_valid", 32'(bus.period_valid), 0);
    chk("mid_rst_overrun", 32'(bus.overrun), 0);
    tick(2);
    chk("mid_rst_timeout", 32'(bus.timeout), 0);
    reset = 1'b0;
    pulse1();
    chk("post_rst_arm", 32'(bus.period_valid), 0);
    tick(3);
    pulse1();
    chk("post_rst_period", 32'(bus.period_out), 4);
    chk("post_rst_valid", 32'(bus.period_valid), 1);

    // Result coincides with accept of the pending value
    bus.period_ready = 1'b0;
    tick(4);
    bus.period_ready = 1'b1;
    pulse1();
    chk("coin_period", 32'(bus.period_out), 5);
    chk("coin_valid", 32'(bus.period_valid), 1);
    chk("coin_overrun", 32'(bus.overrun), 0);
    tick(1);
    chk("coin_consumed", 32'(bus.period_valid), 0);

    // Disable mid-count: edge ignored, next edge only arms
    bus.enable = 1'b0;
    pulse1();
    chk("dis_valid", 32'(bus.period_valid), 0);
    chk("dis_period", 32'(bus.period_out), 5);
    tick(1);
    bus.enable = 1'b1;
    tick(1);
    pulse1();
    chk("reen_arm_valid", 32'(bus.period_valid), 0);
    tick(2);
    pulse1();
    chk("reen_period", 32'(bus.period_out), 3);
    chk("reen_valid", 32'(bus.period_valid), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
